// File: rtl/uart_tx_buffer_if.sv
// Byte handshake between the UART transmit buffer and the serializer.
// The buffer drives valid/data and the serializer answers with ready.
interface uart_tx_buffer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_buffer.sv
// Dual-lane byte buffer between the memory stage and the UART serializer.
// Up to two store bytes per cycle (lane 1 older) enter in program order.
// Bytes leave one per cycle through a valid/ready handshake.
// Admission is judged on the occupancy at the start of the cycle, so a
// same-cycle pop never makes room for a same-cycle push.
module uart_tx_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              we1,
    input  logic [7:0]        data1,
    input  logic              we2,
    input  logic [7:0]        data2,
    input  logic              flush,
    uart_tx_buffer_if.master  tx,
    output logic              stall_req,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [CNT_W-1:0]  free_s;
    logic              pop_s;
    logic              wr0_en_s, wr1_en_s;
    logic [7:0]        wr0_data_s;
    logic [ADDR_W-1:0] wr_ptr_p1_s;
    logic [1:0]        n_push_s;
    logic              drop_s;

    assign free_s      = DEPTH_C - count_q;
    assign wr_ptr_p1_s = wr_ptr_q + PTR_ONE;
    assign tx.tx_valid = (count_q != CNT_ZERO);
    assign tx.tx_data  = mem_q[rd_ptr_q];
    assign pop_s       = tx.tx_valid & tx.tx_ready;
    assign stall_req   = (free_s < CNT_W'(2'd2));
    assign count       = count_q;
    assign overflow    = overflow_q;

    // Decide which lane bytes are admitted and whether any byte is dropped.
    always_comb begin
        wr0_en_s   = 1'b0;
        wr1_en_s   = 1'b0;
        wr0_data_s = data1;
        n_push_s   = 2'd0;
        drop_s     = 1'b0;
        if (flush) begin
            wr0_en_s = 1'b0;
        end else begin
            case ({we1, we2})
                2'b10: begin
                    if (free_s >= CNT_W'(1'b1)) begin
                        wr0_en_s = 1'b1;
                        n_push_s = 2'd1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                2'b01: begin
                    wr0_data_s = data2;
                    if (free_s >= CNT_W'(1'b1)) begin
                        wr0_en_s = 1'b1;
                        n_push_s = 2'd1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (free_s >= CNT_W'(2'd2)) begin
                        wr0_en_s = 1'b1;
                        wr1_en_s = 1'b1;
                        n_push_s = 2'd2;
                    end else if (free_s == CNT_W'(1'b1)) begin
                        wr0_en_s = 1'b1;
                        n_push_s = 2'd1;
                        drop_s   = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                default: begin
                    n_push_s = 2'd0;
                end
            endcase
        end
    end

    // Next pointers, occupancy and sticky overflow; flush clears all but overflow.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop_s;
        if (flush) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + ADDR_W'(n_push_s);
            count_d  = count_q + CNT_W'(n_push_s) - CNT_W'(pop_s);
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rd_ptr_q   <= PTR_ZERO;
            wr_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are not reset, validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (wr0_en_s) begin
            mem_q[wr_ptr_q] <= wr0_data_s;
        end
        if (wr1_en_s) begin
            mem_q[wr_ptr_p1_s] <= data2;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed and model-checked bench for uart_tx_buffer (DEPTH = 16).
module tb_uart_tx_buffer;

    logic       CLK;
    logic       NRST;
    logic       we1, we2, flush;
    logic [7:0] data1, data2;
    logic       stall_req, overflow;
    logic [4:0] count;

    int n_checks;
    int n_fail;

    uart_tx_buffer_if tx_if ();

    uart_tx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .CLK      (CLK),
        .NRST     (NRST),
        .we1      (we1),
        .data1    (data1),
        .we2      (we2),
        .data2    (data2),
        .flush    (flush),
        .tx       (tx_if.master),
        .stall_req(stall_req),
        .count    (count),
        .overflow (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge; inputs are applied and outputs sampled 1 ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        we1 = 1'b0; we2 = 1'b0; flush = 1'b0; tx_if.tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        NRST = 1'b0;
        #2;
        NRST = 1'b1;
    endtask

    task automatic push1(input logic [7:0] d);
        we1 = 1'b1; data1 = d;
        step();
        we1 = 1'b0;
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        we1 = 1'b1; data1 = a; we2 = 1'b1; data2 = b;
        step();
        we1 = 1'b0; we2 = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, 32'(tx_if.tx_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(tx_if.tx_data), 32'(exp));
        tx_if.tx_ready = 1'b1;
        step();
        tx_if.tx_ready = 1'b0;
    endtask

    logic [7:0] q[$];
    logic       m_ovf;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        data1 = 8'h00; data2 = 8'h00;
        NRST = 1'b1;
        idle();
        @(posedge CLK); #1;
        do_reset();

        // Reset state
        check_eq("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // Single push, one-cycle latency, then pop
        push1(8'h41);
        check_eq("single_count", 32'(count), 32'd1);
        expect_pop("single", 8'h41);
        check_eq("single_empty_count", 32'(count), 32'd0);
        check_eq("single_empty_valid", 32'(tx_if.tx_valid), 32'd0);

        // Dual push keeps lane order
        push2(8'h48, 8'h49);
        check_eq("dual_count", 32'(count), 32'd2);
        expect_pop("dual0", 8'h48);
        expect_pop("dual1", 8'h49);
        check_eq("dual_empty", 32'(count), 32'd0);

        // Fill to full; head stays stable while not ready
        for (int i = 0; i < 8; i++) begin
            push2(8'(8'h60 + 2 * i), 8'(8'h61 + 2 * i));
            check_eq("fill_head", 32'(tx_if.tx_data), 32'h60);
            if (i == 6) check_eq("fill14_stall", 32'(stall_req), 32'd0);
        end
        check_eq("full_count", 32'(count), 32'd16);
        check_eq("full_stall", 32'(stall_req), 32'd1);
        check_eq("full_ovf0", 32'(overflow), 32'd0);
        push1(8'h55);
        check_eq("drop_ovf", 32'(overflow), 32'd1);
        check_eq("drop_count", 32'(count), 32'd16);
        // Full + pop + push: push still refused
        we1 = 1'b1; data1 = 8'h56; tx_if.tx_ready = 1'b1;
        step();
        idle();
        check_eq("fullpop_count", 32'(count), 32'd15);
        for (int i = 1; i < 16; i++) expect_pop("fill_drain", 8'(8'h60 + i));
        check_eq("fill_drained", 32'(count), 32'd0);

        // count = 15, dual push stores lane 1 only
        do_reset();
        for (int i = 0; i < 7; i++) push2(8'(8'h80 + 2 * i), 8'(8'h81 + 2 * i));
        push1(8'h8E);
        check_eq("c15_count", 32'(count), 32'd15);
        check_eq("c15_stall", 32'(stall_req), 32'd1);
        push2(8'h01, 8'h02);
        check_eq("c15_ovf", 32'(overflow), 32'd1);
        check_eq("c15_count16", 32'(count), 32'd16);
        for (int i = 0; i < 15; i++) expect_pop("c15_drain", 8'(8'h80 + i));
        expect_pop("c15_last", 8'h01);
        check_eq("c15_empty", 32'(count), 32'd0);

        // Pointer wrap: advance to wr_ptr = 15, then dual push
        do_reset();
        for (int i = 0; i < 15; i++) begin
            push1(8'(i));
            tx_if.tx_ready = 1'b1;
            step();
            tx_if.tx_ready = 1'b0;
        end
        push2(8'hAA, 8'hBB);
        check_eq("wrap_count", 32'(count), 32'd2);
        expect_pop("wrap0", 8'hAA);
        expect_pop("wrap1", 8'hBB);

        // Push and pop together at count = 1
        push1(8'h33);
        we1 = 1'b1; data1 = 8'h34; tx_if.tx_ready = 1'b1;
        step();
        idle();
        check_eq("pp_count", 32'(count), 32'd1);
        expect_pop("pp", 8'h34);

        // Random traffic against a reference queue
        do_reset();
        q.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int free;
            logic pop;
            we1 = 1'($urandom_range(1));
            we2 = 1'($urandom_range(1));
            data1 = 8'($urandom);
            data2 = 8'($urandom);
            tx_if.tx_ready = ($urandom_range(3) == 0);
            free = 16 - q.size();
            pop = tx_if.tx_ready && (q.size() != 0);
            step();
            if (pop) void'(q.pop_front());
            if (we1 && we2) begin
                if (free >= 2) begin q.push_back(data1); q.push_back(data2); end
                else if (free == 1) begin q.push_back(data1); m_ovf = 1'b1; end
                else m_ovf = 1'b1;
            end else if (we1 || we2) begin
                if (free >= 1) q.push_back(we1 ? data1 : data2);
                else m_ovf = 1'b1;
            end
            check_eq("rnd_count", 32'(count), 32'(q.size()));
            check_eq("rnd_valid", 32'(tx_if.tx_valid), 32'(q.size() != 0));
            if (q.size() != 0) check_eq("rnd_data", 32'(tx_if.tx_data), 32'(q[0]));
            check_eq("rnd_ovf", 32'(overflow), 32'(m_ovf));
            check_eq("rnd_stall", 32'(stall_req), 32'(q.size() > 14));
        end
        idle();

        // Flush at count = 5 with overflow set
        do_reset();
        for (int i = 0; i < 8; i++) push2(8'(2 * i), 8'(2 * i + 1));
        push1(8'hEE);
        tx_if.tx_ready = 1'b1;
        repeat (11) step();
        tx_if.tx_ready = 1'b0;
        check_eq("pre_flush_count", 32'(count), 32'd5);
        check_eq("pre_flush_head", 32'(tx_if.tx_data), 32'd11);
        flush = 1'b1; we1 = 1'b1; data1 = 8'h77; tx_if.tx_ready = 1'b1;
        step();
        idle();
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_valid", 32'(tx_if.tx_valid), 32'd0);
        check_eq("flush_ovf", 32'(overflow), 32'd1);
        push1(8'h5A);
        expect_pop("post_flush", 8'h5A);

        // Asynchronous reset mid-operation
        push2(8'h10, 8'h11);
        push1(8'h12);
        check_eq("pre_arst_count", 32'(count), 32'd3);
        NRST = 1'b0;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_valid", 32'(tx_if.tx_valid), 32'd0);
        check_eq("arst_stall", 32'(stall_req), 32'd0);
        check_eq("arst_ovf", 32'(overflow), 32'd0);
        NRST = 1'b1;
        step();
        check_eq("post_arst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Dual-lane byte buffer between the memory stage and the UART serializer. It captures UART-address store data from both issue lanes of the dual-issue pipeline, up to two bytes per cycle, in program order. It presents them one at a time to the serializer through a valid/ready handshake. It also raises a stall request before it can overflow, so bursts of stores to the UART no longer depend on serializer speed.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 4
- ADDR_W, 4, log2(DEPTH)

Ports:
- CLK  input  1  system clock, rising-edge
- NRST  input  1  asynchronous, active-low reset
- we1  input  1  lane-1 store to UART address this cycle; lane 1 is older in program order
- data1  input  8  lane-1 store byte (reg_data2[7:0] of lane 1)
- we2  input  1  lane-2 store to UART address this cycle
- data2  input  8  lane-2 store byte
- flush  input  1  synchronous clear of all entries
- tx_valid  output  1  head entry available
- tx_data  output  8  head entry byte
- tx_ready  input  1  serializer accepts the head byte this cycle
- stall_req  output  1  free space < 2; the pipeline must hold its memory stage
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH
- overflow  output  1  sticky; a byte was dropped because the buffer was full

## Operation
- Storage: DEPTH x 8 register array, with rd_ptr and wr_ptr of ADDR_W bits each. Both pointers wrap modulo DEPTH.
- count is a registered (ADDR_W+1)-bit occupancy; free = DEPTH - count.
- Pop: occurs when tx_valid && tx_ready. rd_ptr advances by 1.
- Push uses free as it stood at the start of the cycle. A same-cycle pop does not create space for a same-cycle push.
- Only we1: if free >= 1, write data1 at wr_ptr and advance wr_ptr by 1. Otherwise drop data1 and set overflow.
- Only we2: same rule, using data2.
- Both we1 and we2:
  - free >= 2: data1 goes to wr_ptr, data2 to wr_ptr+1 (mod DEPTH), and wr_ptr advances by 2.
  - free == 1: data1 is written, data2 is dropped, overflow is set.
  - free == 0: both bytes are dropped and overflow is set.
- count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1. It can never exceed DEPTH or go below 0.
- flush: rd_ptr, wr_ptr and count go to 0 and any same-cycle push or pop is ignored. overflow is NOT cleared by flush; only reset clears it.
- tx_valid = (count != 0). tx_data = mem[rd_ptr] whenever tx_valid; its value when tx_valid = 0 is don't-care.
- stall_req = (free < 2), combinational from registered count. With the pipeline honouring it, overflow never sets.
- tx_data must hold stable while tx_valid = 1 and tx_ready = 0.

## Timing
- Reset (NRST low, asynchronous): rd_ptr = wr_ptr = 0, count = 0, overflow = 0. Hence tx_valid = 0, stall_req = 0. Array contents are not reset.
- Write latency: a byte pushed at edge N is on tx_data with tx_valid = 1 after edge N if the buffer was empty (one cycle).
- Throughput: 2 bytes/cycle in, 1 byte/cycle out.
- Simultaneous push and pop while full is impossible to exploit: a full buffer refuses the push even if a pop occurs.
- Simultaneous push and pop at count == 1: the head is popped and the new byte becomes the head after the edge, so tx_valid stays 1.
- Pointer wrap: a dual push at wr_ptr = DEPTH-1 writes entries DEPTH-1 and 0, giving wr_ptr = 1.
- Reset asserted mid-burst: state clears immediately, with no partial pop. The serializer may have latched a byte already; that byte is not reissued.

## Test plan
- Reset, then a single push we1 = 1 with data1 = 0x41 -> next cycle tx_valid = 1, tx_data = 0x41, count = 1. Then tx_ready = 1 for one cycle -> count = 0, tx_valid = 0.
- Dual push data1 = 0x48, data2 = 0x49 with tx_ready = 0 -> count = 2. Draining gives 0x48 then 0x49, in order.
- Eight dual pushes with tx_ready = 0 (DEPTH = 16) -> count = 16, stall_req = 1 from count = 15. A further we1 with 0x55 -> byte dropped, overflow = 1, count = 16. Drain yields the 16 original bytes.
- count = 15, dual push 0x01/0x02 -> 0x01 stored, 0x02 dropped, overflow = 1, count = 16.
- Wrap: push/pop until wr_ptr = 15, then dual push 0xAA/0xBB -> tx order 0xAA, 0xBB. Random push/pop sequences compared against a reference queue model show zero mismatches.
- Assert flush with count = 5 and overflow = 1 -> count = 0, tx_valid = 0, overflow = 1. Drop NRST mid-operation -> all outputs at reset values asynchronously.
